// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Pipelined carry-lookahead adder/subtractor. The operands are cut into
//   WIDTH/BLOCK groups of BLOCK bits, and each group is resolved in its own
//   pipeline stage. Each stage passes three things forward: the carry out of
//   its group, the sum bits finished so far, and the operand bits that later
//   stages still need. A valid/ready handshake with full backpressure sits on
//   both the input and the output side.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block accepts a beat this cycle (combinational from out_ready)
//   a, b       operands, WIDTH bits
//   cin        carry in (add mode only, ignored when sub=1)
//   sub        0: a+b+cin, 1: a-b
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   sum        result, WIDTH bits
//   cout       carry out of the MSB (in subtract mode, 1 means no borrow)
//   ovf        signed two's-complement overflow
//   zero       sum == 0
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSTAGE = WIDTH / BLOCK;

  // Stage registers. Stage k holds the result of group k.
  logic [NSTAGE-1:0] validQ;
  logic [NSTAGE-1:0] carryQ;
  logic [WIDTH-1:0]  aQ   [NSTAGE];
  logic [WIDTH-1:0]  bQ   [NSTAGE];
  logic [WIDTH-1:0]  sumQ [NSTAGE];
  logic              ovfQ;
  logic              zeroQ;

  // Per-stage next-state values.
  logic [NSTAGE-1:0] advance;
  logic [NSTAGE-1:0] validD;
  logic [NSTAGE-1:0] carryD;
  logic [NSTAGE-1:0] msbCarryInD;
  logic [WIDTH-1:0]  aD   [NSTAGE];
  logic [WIDTH-1:0]  bD   [NSTAGE];
  logic [WIDTH-1:0]  sumD [NSTAGE];
  logic              ovfD;
  logic              zeroD;

  // Working variables for the stage loop.
  logic [WIDTH-1:0]  curA;
  logic [WIDTH-1:0]  curB;
  logic [WIDTH-1:0]  curSum;
  logic              curCarry;
  logic              curValid;
  logic [BLOCK+1:0]  groupRes;
  logic              stallGo;
  int                prevIdx;

  // One lookahead group. Each carry is written out as its full sum of
  // products over generate/propagate and the group carry-in, so no carry
  // waits on the one below it. The result is packed as
  // {carry out, carry into the top bit, sum bits}.
  function automatic logic [BLOCK+1:0] claGroup(input logic [BLOCK-1:0] x,
                                                input logic [BLOCK-1:0] y,
                                                input logic             c0);
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] s;
    logic [BLOCK:0]   c;
    logic             term;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < BLOCK; i++) begin
      term = c0;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    s = p ^ c[BLOCK-1:0];
    return {c[BLOCK], c[BLOCK-1], s};
  endfunction

  // The stall chain runs from the output back to the input. A stage may
  // load when it is empty or when the stage after it is moving. There is
  // no skid buffer, so in_ready follows out_ready combinationally.
  always_comb begin
    advance = '0;
    stallGo = !validQ[NSTAGE-1] || out_ready;
    advance[NSTAGE-1] = stallGo;
    for (int k = NSTAGE - 2; k >= 0; k--) begin
      stallGo    = !validQ[k] || stallGo;
      advance[k] = stallGo;
    end
  end

  // Each stage takes the operand/sum/carry state of the stage before it
  // (stage 0 takes the raw inputs, with b inverted and carry forced to 1 in
  // subtract mode) and resolves its own BLOCK-bit slice.
  always_comb begin
    curA     = '0;
    curB     = '0;
    curSum   = '0;
    curCarry = 1'b0;
    curValid = 1'b0;
    groupRes = '0;
    prevIdx  = 0;
    validD   = '0;
    carryD   = '0;
    msbCarryInD = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      prevIdx = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        curA     = a;
        curB     = sub ? ~b : b;
        curCarry = sub | cin;
        curSum   = '0;
        curValid = in_valid;
      end else begin
        curA     = aQ[prevIdx];
        curB     = bQ[prevIdx];
        curCarry = carryQ[prevIdx];
        curSum   = sumQ[prevIdx];
        curValid = validQ[prevIdx];
      end
      groupRes = claGroup(curA[k*BLOCK +: BLOCK], curB[k*BLOCK +: BLOCK], curCarry);
      curSum[k*BLOCK +: BLOCK] = groupRes[BLOCK-1:0];
      aD[k]          = curA;
      bD[k]          = curB;
      sumD[k]        = curSum;
      carryD[k]      = groupRes[BLOCK+1];
      msbCarryInD[k] = groupRes[BLOCK];
      validD[k]      = curValid;
    end
    ovfD  = msbCarryInD[NSTAGE-1] ^ carryD[NSTAGE-1];
    zeroD = ~|sumD[NSTAGE-1];
  end

  // The pipeline registers. Valid bits move on every advance, so bubbles
  // flow through like beats. The data is loaded only for real beats, which
  // keeps the outputs at their last value while the pipeline is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validQ <= '0;
      carryQ <= '0;
      ovfQ   <= 1'b0;
      zeroQ  <= 1'b0;
      for (int k = 0; k < NSTAGE; k++) begin
        aQ[k]   <= '0;
        bQ[k]   <= '0;
        sumQ[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSTAGE; k++) begin
        if (advance[k]) begin
          validQ[k] <= validD[k];
          if (validD[k]) begin
            aQ[k]     <= aD[k];
            bQ[k]     <= bD[k];
            sumQ[k]   <= sumD[k];
            carryQ[k] <= carryD[k];
          end
        end
      end
      if (advance[NSTAGE-1] && validD[NSTAGE-1]) begin
        ovfQ  <= ovfD;
        zeroQ <= zeroD;
      end
    end
  end

  assign in_ready  = advance[0];
  assign out_valid = validQ[NSTAGE-1];
  assign sum       = sumQ[NSTAGE-1];
  assign cout      = carryQ[NSTAGE-1];
  assign ovf       = ovfQ;
  assign zero      = zeroQ;

endmodule
